// File: rtl/vedic_mac_acc_if.sv
// Operand/result handshake bundle for the vedic multiply-accumulate block.
// The master drives operands and the result ready; the slave is the MAC.
interface vedic_mac_acc_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/vedic_mac_acc.sv
// Saturating unsigned dot-product engine: len beats of a*b are summed into
// an ACC_W-bit accumulator, with products formed by a vedic 8x8 multiplier.
module vedic_mac_acc #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input logic           clk,
  input logic           rst,
  vedic_mac_acc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic [15:0]      prod_s;
  logic [ACC_W:0]   sum_s;
  logic             in_ready_s, out_valid_s, accept_s, start_s;

  vedic8 u_mul (
    .a_i (bus.a),
    .b_i (bus.b),
    .p_o (prod_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == {LEN_W{1'b0}}) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (cnt_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      RUN:     in_ready_s  = 1'b1;
      DONE:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  assign accept_s = bus.in_valid & in_ready_s;
  assign start_s  = (state_q == IDLE) & bus.start;
  assign sum_s    = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod_q};

  // The product is registered one beat ahead of accumulation, so the last
  // product lands in acc on the DRAIN -> DONE edge.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    prod_d   = prod_q;
    prod_v_d = accept_s;
    if (start_s) begin
      acc_d    = {ACC_W{1'b0}};
      ovf_d    = 1'b0;
      cnt_d    = bus.len;
      prod_v_d = 1'b0;
    end else begin
      if (accept_s) begin
        cnt_d  = cnt_q - LEN_W'(1);
        prod_d = prod_s;
      end else begin
        cnt_d  = cnt_q;
        prod_d = prod_q;
      end
      if (prod_v_q && sum_s[ACC_W]) begin
        acc_d = {ACC_W{1'b1}};
        ovf_d = 1'b1;
      end else if (prod_v_q) begin
        acc_d = sum_s[ACC_W-1:0];
      end else begin
        acc_d = acc_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= {LEN_W{1'b0}};
      acc_q    <= {ACC_W{1'b0}};
      ovf_q    <= 1'b0;
      prod_q   <= 16'h0000;
      prod_v_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// Unsigned 8x8 multiplier built from Urdhva-Tiryagbhyam 2x2 and 4x4 blocks.
module vedic8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic t0, t1, c, hh;
    t0 = x[1] & y[0];
    t1 = x[0] & y[1];
    c  = t0 & t1;
    hh = x[1] & y[1];
    return {hh & c, hh ^ c, t0 ^ t1, x[0] & y[0]};
  endfunction

  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic2(x[1:0], y[1:0]);
    q1 = vedic2(x[3:2], y[1:0]);
    q2 = vedic2(x[1:0], y[3:2]);
    q3 = vedic2(x[3:2], y[3:2]);
    return {q3, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00};
  endfunction

  logic [7:0] q0_s, q1_s, q2_s, q3_s;

  assign q0_s = vedic4(a_i[3:0], b_i[3:0]);
  assign q1_s = vedic4(a_i[7:4], b_i[3:0]);
  assign q2_s = vedic4(a_i[3:0], b_i[7:4]);
  assign q3_s = vedic4(a_i[7:4], b_i[7:4]);
  assign p_o  = {q3_s, q0_s} + {4'h0, q1_s, 4'h0} + {4'h0, q2_s, 4'h0};

endmodule

// File: doc/vedic_mac_acc.md
VEDIC_MAC_ACC -- requirements
Module: vedic_mac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator and result width, legal range 16..32.
REQ-002 SHALL have parameter LEN_W, default 8: width of the term-count input.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that begins a dot-product; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W: number of operand pairs, sampled with start.
REQ-007 SHALL have port in_valid, input, 1: operand pair a/b is valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts operands.
REQ-009 SHALL have port a, input, 8: unsigned multiplicand.
REQ-010 SHALL have port b, input, 8: unsigned multiplier.
REQ-011 SHALL have port out_valid, output, 1: result is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port acc_out, output, ACC_W: accumulated sum of products.
REQ-014 SHALL have port ovf, output, 1: sticky saturation flag for the current result.

Function
REQ-015 SHALL compute each product with one vedic8 instance, giving an unsigned 16-bit product, and SHALL NOT use the * operator.
REQ-016 SHALL register the product (prod_q) and a product-valid bit (prod_v) on the edge that accepts a beat.
REQ-017 SHALL accept a beat on any edge where in_valid and in_ready are both 1.
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE, in_ready and out_valid SHALL be 0.
REQ-020 In IDLE, start with len!=0 SHALL clear acc, ovf and prod_v, load cnt=len, and move the FSM to RUN.
REQ-021 In IDLE, start with len==0 SHALL clear acc and ovf and move the FSM to DONE.
REQ-022 In RUN, in_ready SHALL be 1 and each accepted beat SHALL decrement cnt.
REQ-023 In RUN, the beat accepted with cnt==1 SHALL move the FSM to DRAIN.
REQ-024 In RUN, cycles with in_valid low SHALL leave state, cnt and acc unchanged; there is no timeout.
REQ-025 In DRAIN, in_ready SHALL be 0, and the FSM SHALL move to DONE unconditionally after one cycle.
REQ-026 In DONE, out_valid SHALL be 1, and acc_out and ovf SHALL hold stable until out_valid and out_ready are both 1.
REQ-027 In DONE, the edge with out_valid and out_ready both 1 SHALL move the FSM to IDLE.
REQ-028 Each edge with prod_v=1 SHALL update acc to acc plus the zero-extended prod_q.
REQ-029 If that sum exceeds 2^ACC_W-1, acc SHALL saturate to all-ones and ovf SHALL set; ovf SHALL stay set until the next start.
REQ-030 Latency: out_valid SHALL rise on the second rising edge after the edge that accepts the last beat.
REQ-031 Latency for len==0: out_valid SHALL rise on the edge following start.
REQ-032 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-033 acc_out SHALL show acc continuously; acc_out is defined only while out_valid=1.

Reset
REQ-034 With rst=1 at a rising edge, the FSM SHALL go to IDLE and acc, cnt, prod_q, prod_v and ovf SHALL clear to 0; rst SHALL take priority over all other inputs.
REQ-035 After reset, in_ready, out_valid, acc_out and ovf SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard the partial sum, and no out_valid SHALL follow.

Verification
REQ-037 Bench SHALL cover: len=1, beat (255,255) -> acc_out=65025 (0x00FE01), ovf=0, out_valid 2 cycles after acceptance.
REQ-038 Bench SHALL cover: len=4, beats (3,5),(7,11),(0,200),(16,16) with in_valid gaps of 0-3 cycles -> acc_out=348, ovf=0.
REQ-039 Bench SHALL cover: ACC_W=16, len=2, beats (255,255),(255,255) -> acc_out=0xFFFF, ovf=1; the next run with len=1, beat (2,3) -> acc_out=6, ovf=0.
REQ-040 Bench SHALL cover: out_ready held low 5 cycles in DONE -> acc_out and out_valid stable; no beat accepted; start ignored.
REQ-041 Bench SHALL cover: rst pulsed after 2 of 4 beats -> in_ready=0 and out_valid=0 the next cycle; a fresh run with len=1, beat (10,10) -> acc_out=100.
REQ-042 Bench SHALL cover: len=0 start -> out_valid=1 with acc_out=0 on the following edge, and in_ready is never 1.
